// File: rtl/alu_result_buffer.sv
// alu_result_buffer: a two-entry elastic buffer placed behind the gated pass mux.
// Each accepted result is stored together with its zero, negative and gated flags,
// which are computed once when the result is captured. A sticky gate_err is raised
// whenever a gated-off result (in_sel=0) arrives with non-zero data.
module alu_result_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_sel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_zero,
    output logic                       out_neg,
    output logic                       out_gated,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       gate_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Flags ride alongside the data so the output never recomputes them.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             zero;
        logic             neg;
        logic             gated;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          wr_entry;
    entry_t          head;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            push;
    logic            pop;

    // in_ready is derived from the count alone; a pop in the same cycle cannot make
    // room for a push, which keeps in_ready off the out_ready path.
    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Capture-time flag computation for the incoming result.
    always_comb begin
        wr_entry       = '0;
        wr_entry.data  = in_data;
        wr_entry.zero  = ~|in_data;
        wr_entry.neg   = in_data[WIDTH-1];
        wr_entry.gated = ~in_sel;
    end

    // Per-entry storage; contents are don't-care while not occupied, so no reset.
    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        // Write this slot when a push targets it and no flush is pending.
        always_ff @(posedge clk) begin
            if (push && !clr && (wr_ptr == AW'(e))) begin
                mem[e] <= wr_entry;
            end
        end
    end

    // Pointer and occupancy bookkeeping; flush wins over any push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Sticky check that a gated-off result really arrived as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_err <= 1'b0;
        end else if (clr) begin
            gate_err <= 1'b0;
        end else if (push && !in_sel && (in_data != '0)) begin
            gate_err <= 1'b1;
        end
    end

    // Head entry presented to the consumer, masked to zero while empty.
    always_comb begin
        head      = mem[rd_ptr];
        out_data  = '0;
        out_zero  = 1'b0;
        out_neg   = 1'b0;
        out_gated = 1'b0;
        if (out_valid) begin
            out_data  = head.data;
            out_zero  = head.zero;
            out_neg   = head.neg;
            out_gated = head.gated;
        end
    end

endmodule
